// File: rtl/e_redirect_pkg.sv
// e_redirect_pkg: shared opcode and branch funct3 encodings, E register
// layout and the control-flow target helper used by the execute stage.
package e_redirect_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Control-flow operands captured in the D->E pipeline register.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        valid;
  } e_reg_t;

  // JALR drops bit 0 of rs1+imm; BRANCH and JAL are PC-relative.
  // Both sums wrap modulo 2^32.
  function automatic logic [31:0] calc_target(input logic [6:0]  opcode,
                                              input logic [31:0] pc,
                                              input logic [31:0] rs1,
                                              input logic [31:0] imm);
    logic [31:0] sum;
    if (opcode == OP_JALR) begin
      sum = rs1 + imm;
      sum[0] = 1'b0;
    end else begin
      sum = pc + imm;
    end
    return sum;
  endfunction

endpackage

// File: rtl/e_redirect_if.sv
// e_redirect_if: decode-to-execute operand bus plus the redirect outputs
// that fetch consumes. The slave side is the execute stage.
interface e_redirect_if;
  logic        E_stall_i;
  logic        E_bubble_i;
  logic [6:0]  d_opcode_i;
  logic [2:0]  d_funct3_i;
  logic [31:0] d_pc_i;
  logic [31:0] d_rs1_i;
  logic [31:0] d_rs2_i;
  logic [31:0] d_imm_i;
  logic [6:0]  E_opcode_o;
  logic        e_Cnd_o;
  logic [31:0] e_valE_o;
  logic [31:0] e_link_o;
  logic        e_misalign_o;
  logic        E_valid_o;

  modport master (
    output E_stall_i, E_bubble_i, d_opcode_i, d_funct3_i, d_pc_i,
           d_rs1_i, d_rs2_i, d_imm_i,
    input  E_opcode_o, e_Cnd_o, e_valE_o, e_link_o, e_misalign_o, E_valid_o
  );

  modport slave (
    input  E_stall_i, E_bubble_i, d_opcode_i, d_funct3_i, d_pc_i,
           d_rs1_i, d_rs2_i, d_imm_i,
    output E_opcode_o, e_Cnd_o, e_valE_o, e_link_o, e_misalign_o, E_valid_o
  );
endinterface

// File: rtl/e_redirect_br_cmp.sv
// br_cmp: funct3-driven branch comparator, purely combinational so a later
// branch predictor checker can reuse it.
module br_cmp
  import e_redirect_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  funct3_i,
  output logic        taken_o
);

  // Select the comparison named by funct3; reserved encodings never take.
  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      BR_BEQ:  taken_o = (rs1_i == rs2_i);
      BR_BNE:  taken_o = (rs1_i != rs2_i);
      BR_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      BR_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      BR_BLTU: taken_o = (rs1_i <  rs2_i);
      BR_BGEU: taken_o = (rs1_i >= rs2_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/e_redirect.sv
// e_redirect: execute-stage control-flow resolution. Holds the D->E
// register, resolves BRANCH/JAL/JALR, drives the fetch redirect and squashes
// the two wrong-path instructions that follow a taken redirect.
module e_redirect
  import e_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic      clk_i,
  input  logic      rst_i,
  e_redirect_if.slave bus
);

  e_reg_t      e_q, e_d;
  logic        squash_q, squash_d;
  logic        cmp_taken;
  logic        taken;
  logic        misalign;
  logic        redirect_ok;
  logic [31:0] target;

  br_cmp u_br_cmp (
    .rs1_i    (e_q.rs1),
    .rs2_i    (e_q.rs2),
    .funct3_i (e_q.funct3),
    .taken_o  (cmp_taken)
  );

  // Decide whether the live instruction in E changes control flow.
  always_comb begin
    taken = 1'b0;
    if (e_q.valid) begin
      case (e_q.opcode)
        OP_JAL, OP_JALR: taken = 1'b1;
        OP_BRANCH:       taken = cmp_taken;
        default:         taken = 1'b0;
      endcase
    end
  end

  assign target      = calc_target(e_q.opcode, e_q.pc, e_q.rs1, e_q.imm);
  assign misalign    = taken & target[1];
  assign redirect_ok = taken & ~misalign;

  assign bus.e_Cnd_o      = redirect_ok & ~bus.E_stall_i;
  assign bus.e_valE_o     = bus.e_Cnd_o ? target : 32'h0;
  assign bus.e_misalign_o = misalign;
  assign bus.E_opcode_o   = (e_q.valid & ~misalign) ? e_q.opcode : 7'h0;
  assign bus.E_valid_o    = e_q.valid;
  assign bus.e_link_o     = e_q.pc + 32'd4;

  // Next E contents: stall holds everything, otherwise decode's instruction
  // is captured and killed while redirecting, squashing or bubbling.
  always_comb begin
    e_d      = e_q;
    squash_d = squash_q;
    if (!bus.E_stall_i) begin
      e_d.opcode = bus.d_opcode_i;
      e_d.funct3 = bus.d_funct3_i;
      e_d.pc     = bus.d_pc_i;
      e_d.rs1    = bus.d_rs1_i;
      e_d.rs2    = bus.d_rs2_i;
      e_d.imm    = bus.d_imm_i;
      e_d.valid  = 1'b1;
      if (redirect_ok) begin
        e_d.valid = 1'b0;
        squash_d  = 1'b1;
      end else if (squash_q) begin
        e_d.valid = 1'b0;
        squash_d  = 1'b0;
      end else if (bus.E_bubble_i) begin
        e_d.valid = 1'b0;
      end
    end
  end

  // E register and squash counter with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_q      <= '0;
      e_q.pc   <= RESET_PC;
      squash_q <= 1'b0;
    end else begin
      e_q      <= e_d;
      squash_q <= squash_d;
    end
  end

endmodule

// File: tb/tb_e_redirect.sv
// tb_e_redirect: directed and randomized checks of the execute redirect block
// against a behavioural model; expected outputs go through a scoreboard queue.
module tb_e_redirect;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [6:0]  OPC_BR   = 7'b1100011;
  localparam logic [6:0]  OPC_JAL  = 7'b1101111;
  localparam logic [6:0]  OPC_JALR = 7'b1100111;
  localparam logic [6:0]  OPC_ALU  = 7'b0110011;

  typedef struct {
    logic [6:0]  opcode;
    logic        cnd;
    logic [31:0] valE;
    logic [31:0] link;
    logic        misalign;
    logic        valid;
  } expect_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  e_redirect_if bus ();

  e_redirect #(.RESET_PC(RESET_PC)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int errorCount = 0;
  int checkCount = 0;
  expect_t scoreQ[$];

  // Reference model: what instruction sits in E and how many wrong-path
  // slots remain to be discarded.
  logic        mKnown = 1'b0;
  logic        mValid;
  logic [6:0]  mOp;
  logic [2:0]  mF3;
  logic [31:0] mPc, mRs1, mRs2, mImm;
  int          wrongPathLeft = 0;

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic logic modelTaken();
    logic t;
    t = 1'b0;
    if (mOp == OPC_JAL || mOp == OPC_JALR) t = 1'b1;
    else if (mOp == OPC_BR) begin
      case (mF3)
        3'd0: t = (mRs1 == mRs2);
        3'd1: t = (mRs1 != mRs2);
        3'd4: t = ($signed(mRs1) <  $signed(mRs2));
        3'd5: t = ($signed(mRs1) >= $signed(mRs2));
        3'd6: t = (mRs1 <  mRs2);
        3'd7: t = (mRs1 >= mRs2);
        default: t = 1'b0;
      endcase
    end
    return t & mValid;
  endfunction

  function automatic logic [31:0] modelTarget();
    if (mOp == OPC_JALR) return (mRs1 + mImm) & 32'hFFFF_FFFE;
    return mPc + mImm;
  endfunction

  function automatic expect_t modelExpect(input logic stall);
    expect_t e;
    logic t, mis;
    t   = modelTaken();
    mis = t && modelTarget()[1];
    e.cnd      = t && !mis && !stall;
    e.valE     = e.cnd ? modelTarget() : 32'h0;
    e.opcode   = (mValid && !mis) ? mOp : 7'h0;
    e.link     = mPc + 32'd4;
    e.misalign = mis;
    e.valid    = mValid;
    return e;
  endfunction

  task automatic modelStep(input logic rst, input logic stall, input logic bubble);
    logic redirect;
    if (rst) begin
      mKnown = 1'b1; mValid = 1'b0; mOp = '0; mF3 = '0;
      mPc = RESET_PC; mRs1 = '0; mRs2 = '0; mImm = '0;
      wrongPathLeft = 0;
    end else if (!stall) begin
      redirect = modelTaken() && !modelTarget()[1];
      if (redirect) wrongPathLeft = 2;
      mOp = bus.d_opcode_i; mF3 = bus.d_funct3_i; mPc = bus.d_pc_i;
      mRs1 = bus.d_rs1_i; mRs2 = bus.d_rs2_i; mImm = bus.d_imm_i;
      mValid = (wrongPathLeft == 0) && !bubble;
      if (wrongPathLeft > 0) wrongPathLeft--;
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, advance the clock.
  task automatic applyStimulus(input logic rst, input logic stall, input logic bubble,
                               input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] pc, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm);
    rst_i = rst;
    bus.E_stall_i = stall; bus.E_bubble_i = bubble;
    bus.d_opcode_i = op; bus.d_funct3_i = f3; bus.d_pc_i = pc;
    bus.d_rs1_i = rs1; bus.d_rs2_i = rs2; bus.d_imm_i = imm;
    #1;
    if (mKnown) scoreQ.push_back(modelExpect(stall));
    @(posedge clk_i);
    modelStep(rst, stall, bubble);
    #1;
  endtask

  task automatic filler(input logic [31:0] pc);
    applyStimulus(1'b0, 1'b0, 1'b0, OPC_ALU, 3'd0, pc, 32'h11, 32'h22, 32'h4);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk_i) begin
    expect_t e;
    while (scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      checkOutput("sb_opcode", 32'(bus.E_opcode_o), 32'(e.opcode));
      checkOutput("sb_cnd", 32'(bus.e_Cnd_o), 32'(e.cnd));
      checkOutput("sb_valE", bus.e_valE_o, e.valE);
      checkOutput("sb_link", bus.e_link_o, e.link);
      checkOutput("sb_misalign", 32'(bus.e_misalign_o), 32'(e.misalign));
      checkOutput("sb_valid", 32'(bus.E_valid_o), 32'(e.valid));
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [6:0] op;
    logic [31:0] rs1, rs2, imm;
    int r;
    @(posedge clk_i); #1;

    // Reset with garbage decode inputs
    applyStimulus(1'b1, 1'b0, 1'b0, OPC_JAL, 3'd5, 32'hDEAD_BEEF, 32'h1234, 32'h5678, 32'h9);
    applyStimulus(1'b1, 1'b0, 1'b0, OPC_BR, 3'd0, 32'hCAFE_F00D, 32'h7, 32'h7, 32'h40);
    checkOutput("rst_opcode", 32'(bus.E_opcode_o), 32'h0);
    checkOutput("rst_cnd", 32'(bus.e_Cnd_o), 32'h0);
    checkOutput("rst_valE", bus.e_valE_o, 32'h0);
    checkOutput("rst_misalign", 32'(bus.e_misalign_o), 32'h0);
    checkOutput("rst_valid", 32'(bus.E_valid_o), 32'h0);

    // Taken BEQ followed by two squashed slots
    applyStimulus(1'b0, 1'b0, 1'b0, OPC_BR, 3'd0, 32'h8000_0010, 32'd5, 32'd5, 32'h20);
    checkOutput("beq_cnd", 32'(bus.e_Cnd_o), 32'h1);
    checkOutput("beq_valE", bus.e_valE_o, 32'h8000_0030);
    filler(32'h8000_0014);
    checkOutput("beq_sq1_valid", 32'(bus.E_valid_o), 32'h0);
    checkOutput("beq_sq1_opcode", 32'(bus.E_opcode_o), 32'h0);
    checkOutput("beq_sq1_cnd", 32'(bus.e_Cnd_o), 32'h0);
    filler(32'h8000_0018);
    checkOutput("beq_sq2_valid", 32'(bus.E_valid_o), 32'h0);
    checkOutput("beq_sq2_opcode", 32'(bus.E_opcode_o), 32'h0);
    filler(32'h8000_0030);
    checkOutput("beq_third_valid", 32'(bus.E_valid_o), 32'h1);
    checkOutput("beq_third_opcode", 32'(bus.E_opcode_o), 32'(OPC_ALU));

    // BLT signed taken, BLTU not taken
    applyStimulus(1'b0, 1'b0, 1'b0, OPC_BR, 3'd4, 32'h8000_0034, 32'hFFFF_FFFF, 32'd1, 32'h40);
    checkOutput("blt_cnd", 32'(bus.e_Cnd_o), 32'h1);
    checkOutput("blt_valE", bus.e_valE_o, 32'h8000_0074);
    filler(32'h8000_0038);
    filler(32'h8000_003C);
    applyStimulus(1'b0, 1'b0, 1'b0, OPC_BR, 3'd6, 32'h8000_0074, 32'hFFFF_FFFF, 32'd1, 32'h40);
    checkOutput("bltu_cnd", 32'(bus.e_Cnd_o), 32'h0);
    checkOutput("bltu_valE", bus.e_valE_o, 32'h0);
    filler(32'h8000_0078);
    checkOutput("bltu_nosquash_valid", 32'(bus.E_valid_o), 32'h1);

    // JALR aligned then misaligned
    applyStimulus(1'b0, 1'b0, 1'b0, OPC_JALR, 3'd0, 32'h8000_0200, 32'h8000_0101, 32'h0, 32'h0);
    checkOutput("jalr_cnd", 32'(bus.e_Cnd_o), 32'h1);
    checkOutput("jalr_valE", bus.e_valE_o, 32'h8000_0100);
    checkOutput("jalr_link", bus.e_link_o, 32'h8000_0204);
    filler(32'h8000_0204);
    filler(32'h8000_0208);
    applyStimulus(1'b0, 1'b0, 1'b0, OPC_JALR, 3'd0, 32'h8000_0100, 32'h8000_0102, 32'h0, 32'h0);
    checkOutput("jalr_mis_flag", 32'(bus.e_misalign_o), 32'h1);
    checkOutput("jalr_mis_cnd", 32'(bus.e_Cnd_o), 32'h0);
    checkOutput("jalr_mis_opcode", 32'(bus.E_opcode_o), 32'h0);
    filler(32'h8000_0104);
    checkOutput("jalr_mis_nosquash", 32'(bus.E_valid_o), 32'h1);

    // Stall during a taken JAL
    applyStimulus(1'b0, 1'b0, 1'b0, OPC_JAL, 3'd0, 32'h8000_0300, 32'h0, 32'h0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, OPC_ALU, 3'd0, 32'h8000_0304 + 32'(i), 32'h1, 32'h2, 32'h3);
      checkOutput("stall_cnd", 32'(bus.e_Cnd_o), 32'h0);
      checkOutput("stall_opcode", 32'(bus.E_opcode_o), 32'(OPC_JAL));
      checkOutput("stall_link", bus.e_link_o, 32'h8000_0304);
    end
    filler(32'h8000_0304);
    checkOutput("release_sq1_valid", 32'(bus.E_valid_o), 32'h0);
    filler(32'h8000_0308);
    checkOutput("release_sq2_valid", 32'(bus.E_valid_o), 32'h0);
    filler(32'h8000_0400);
    checkOutput("release_live_valid", 32'(bus.E_valid_o), 32'h1);

    // Target wrap, then reset during the first squash cycle
    applyStimulus(1'b0, 1'b0, 1'b0, OPC_JAL, 3'd0, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20);
    checkOutput("wrap_valE", bus.e_valE_o, 32'h0000_0010);
    filler(32'hFFFF_FFF4);
    applyStimulus(1'b1, 1'b0, 1'b0, OPC_ALU, 3'd0, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0);
    filler(32'h0000_0010);
    checkOutput("post_rst_valid", 32'(bus.E_valid_o), 32'h1);
    checkOutput("post_rst_opcode", 32'(bus.E_opcode_o), 32'(OPC_ALU));

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: op = OPC_BR;
        1: op = OPC_JAL;
        2: op = OPC_JALR;
        3: op = OPC_ALU;
        default: op = 7'($urandom);
      endcase
      rs1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
      rs2 = ($urandom_range(0, 2) == 0) ? rs1 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3)));
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFC;
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 9) == 0, op, 3'($urandom), $urandom & 32'hFFFF_FFFC,
                    rs1, rs2, imm);
    end

    @(negedge clk_i);
    #1;
    if (scoreQ.size() != 0) checkOutput("sb_drain", 32'(scoreQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
